operand_packetizer: RTL and testbench
=====================================

Name: operand_packetizer

Overview:
- Sits directly upstream of the operand collector.
- Assembles a UART RX byte stream, MSB first, into 48-bit command words.
- Word layout: [47:45] app, [44] a_or_b, [43] sel, [42:40] packet, [39:0] data.
- Validates the header and packet order, then drives each accepted word onto a held 48-bit bus for the collector. Malformed, out-of-order or stalled input never reaches the collector.

Parameters:
GAP_TIMEOUT, 100000, idle clock cycles allowed between bytes of one word before the partial word is discarded
CHECK_ORDER, 1, 1 = enforce A0,A1,B0,B1 sequence; 0 = header check only

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe per byte; back-to-back allowed
dataout  output  48  last accepted word, held stable until the next accepted word
word_valid  output  1  one-cycle pulse when dataout updates
word_count  output  16  count of accepted words, wraps at 16'hFFFF->0
busy  output  1  high while a partial word is held (byte index != 0)
err_header  output  1  one-cycle pulse: word dropped, bad header
err_order  output  1  one-cycle pulse: word dropped, sequence/app mismatch
err_timeout  output  1  one-cycle pulse: partial word dropped on gap timeout

Behaviour:
- Reset (synchronous, any state, mid-word included):
  - dataout=0, word_count=0, all pulses=0, busy=0.
  - Byte index=0, gap counter=0, sequence=EXP_A0, latched app=0.
- Assembly:
  - Byte index 0..5; each rx_valid shifts rx_data into a 40-bit holding register and increments the index.
  - On the rx_valid with index=5, the candidate word is {holding[39:0], rx_data}.
  - The candidate is checked in the same cycle; index returns to 0.
- Latency: dataout, word_valid and err_* update on the edge that samples the 6th byte; visible one cycle later.
- Header check (first priority): app must be 1, 2 or 3 and packet must be 0 or 1. On failure: err_header pulse; dataout, word_count and sequence unchanged.
- Order FSM (CHECK_ORDER=1); expected (a_or_b,packet) per state:
  - EXP_A0 expects (0,0).
  - EXP_A1 expects (0,1).
  - EXP_B0 expects (1,0).
  - EXP_B1 expects (1,1).
- Order FSM transitions:
  - A header-valid A0 is accepted from any state (resync). It latches app and moves to EXP_A1.
  - In other states, the word is accepted only if (a_or_b,packet) matches the state and app equals the latched app. Acceptance advances the state: A1 -> EXP_B0, B0 -> EXP_B1, B1 -> EXP_A0.
  - Mismatch: err_order pulse, word dropped, state unchanged.
- CHECK_ORDER=0: every header-valid word is accepted; the order FSM is frozen at EXP_A0.
- Accept: dataout<=word, word_valid=1 for one cycle, word_count+=1. dataout never returns to 0 except by reset, because the collector clears its operands on app=0.
- Gap timeout:
  - The counter runs only while busy. It increments on each cycle without rx_valid and clears on every rx_valid.
  - When the counter reaches GAP_TIMEOUT: index=0, holding register discarded, err_timeout pulse, counter=0.
  - If rx_valid arrives in the cycle the counter would reach GAP_TIMEOUT, the byte is taken and no timeout occurs.
- Error pulses are mutually exclusive within one cycle. err_timeout cannot coincide with a word check, because a check implies rx_valid.
- sel and data bits are passed through unchecked.

Test Plan:
- Reset, then bytes 20 00 00 00 00 05 -> one cycle after the 6th byte: dataout=48'h200000000005, word_valid high exactly one cycle, word_count=1, no err.
- 24 back-to-back bytes: 20..01, 21..02, 30..03, 31..07 -> four word_valid pulses in order; final dataout=48'h310000000007; word_count=4; FSM back at EXP_A0.
- Bytes 22 00 00 00 00 09 (packet=2), then 00 00 00 00 00 01 (app=0) -> two err_header pulses; dataout and word_count unchanged.
- After reset send 31 00 00 00 00 01 -> err_order, dropped. Then A0 (20..) -> accepted. Then A1 with app=2 (41..) -> err_order. Then 21.. -> accepted, state EXP_B0.
- With GAP_TIMEOUT=16:
  - Send 3 bytes, then 16 idle cycles -> err_timeout pulse, busy=0; the next 6 bytes form a clean word.
  - Repeat with a 4th byte arriving on idle cycle 16 -> no timeout; the word completes normally.
- Assert rst after 4 bytes of a word -> all outputs 0, busy=0. Then 20 00 00 00 00 0A -> accepted, word_count=1.

Source files
------------

// File: rtl/operand_packetizer.sv
// Collects six MSB-first UART bytes into a 48-bit command word, validates header
// and A0/A1/B0/B1 ordering, and presents accepted words on a held bus.
module operand_packetizer #(
    parameter int GAP_TIMEOUT = 100000,
    parameter bit CHECK_ORDER = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [47:0] dataout,
    output logic        word_valid,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        err_header,
    output logic        err_order,
    output logic        err_timeout
);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

    typedef enum logic [1:0] {EXP_A0, EXP_A1, EXP_B0, EXP_B1} seq_t;

    logic [2:0]    idx_reg;
    logic [GW-1:0] gap_reg;
    seq_t          seq_reg;
    seq_t          seq_next;
    logic [2:0]    app_reg;
    logic [39:0]   hold_reg;
    logic [47:0]   dataout_reg;
    logic [15:0]   count_reg;
    logic          word_valid_reg;
    logic          err_header_reg;
    logic          err_order_reg;
    logic          err_timeout_reg;

    logic [47:0] cand_word;
    logic [2:0]  cand_app;
    logic [2:0]  cand_pkt;
    logic        cand_ab;
    logic        word_done;
    logic        header_ok;
    logic        is_a0;
    logic        order_ok;
    logic        accept;
    logic        order_fail;

    // Holding register: each byte lane shifts into the next on every received byte.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_reg[gi*8 +: 8] <= 8'h00;
                end else if (rx_valid) begin
                    if (gi == 0) begin
                        hold_reg[gi*8 +: 8] <= rx_data;
                    end else begin
                        hold_reg[gi*8 +: 8] <= hold_reg[(gi-1)*8 +: 8];
                    end
                end
            end
        end
    endgenerate

    assign cand_word = {hold_reg, rx_data};
    assign cand_app  = cand_word[47:45];
    assign cand_ab   = cand_word[44];
    assign cand_pkt  = cand_word[42:40];
    assign word_done = rx_valid && (idx_reg == 3'd5);
    assign header_ok = (cand_app != 3'd0) && (cand_app[2] == 1'b0) && (cand_pkt[2:1] == 2'b00);
    assign is_a0     = !cand_ab && !cand_pkt[0];

    always_comb begin
        seq_next = EXP_A0;
        order_ok = 1'b0;
        case (seq_reg)
            EXP_A1: begin
                seq_next = EXP_B0;
                order_ok = !cand_ab && cand_pkt[0];
            end
            EXP_B0: begin
                seq_next = EXP_B1;
                order_ok = cand_ab && !cand_pkt[0];
            end
            EXP_B1: begin
                seq_next = EXP_A0;
                order_ok = cand_ab && cand_pkt[0];
            end
            default: begin
                seq_next = EXP_A0;
                order_ok = 1'b0;
            end
        endcase
        order_ok = order_ok && (cand_app == app_reg);
    end

    // An A0 always resynchronises the sequence, whatever state it arrives in.
    assign accept     = word_done && header_ok && (!CHECK_ORDER || is_a0 || order_ok);
    assign order_fail = word_done && header_ok && CHECK_ORDER && !is_a0 && !order_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg         <= 3'd0;
            gap_reg         <= '0;
            seq_reg         <= EXP_A0;
            app_reg         <= 3'd0;
            dataout_reg     <= 48'h0;
            count_reg       <= 16'h0;
            word_valid_reg  <= 1'b0;
            err_header_reg  <= 1'b0;
            err_order_reg   <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            word_valid_reg  <= accept;
            err_header_reg  <= word_done && !header_ok;
            err_order_reg   <= order_fail;
            err_timeout_reg <= 1'b0;

            if (rx_valid) begin
                gap_reg <= '0;
                idx_reg <= word_done ? 3'd0 : idx_reg + 3'd1;
            end else if (idx_reg != 3'd0) begin
                if (gap_reg == GAP_LAST) begin
                    idx_reg         <= 3'd0;
                    gap_reg         <= '0;
                    err_timeout_reg <= 1'b1;
                end else begin
                    gap_reg <= gap_reg + 1'b1;
                end
            end

            if (accept) begin
                dataout_reg <= cand_word;
                count_reg   <= count_reg + 16'd1;
                if (CHECK_ORDER) begin
                    seq_reg <= is_a0 ? EXP_A1 : seq_next;
                    if (is_a0) begin
                        app_reg <= cand_app;
                    end
                end
            end
        end
    end

    assign dataout     = dataout_reg;
    assign word_valid  = word_valid_reg;
    assign word_count  = count_reg;
    assign busy        = (idx_reg != 3'd0);
    assign err_header  = err_header_reg;
    assign err_order   = err_order_reg;
    assign err_timeout = err_timeout_reg;
endmodule

// File: tb/tb_operand_packetizer.sv
// Directed plus randomized bench for operand_packetizer against a word-level
// reference model of header and sequence acceptance.
module tb_operand_packetizer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [47:0] dataout;
    logic        word_valid;
    logic [15:0] word_count;
    logic        busy;
    logic        err_header;
    logic        err_order;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    // Reference model state: position in the A0,A1,B0,B1 list, latched app, last output.
    int          m_pos;
    logic [2:0]  m_app;
    logic [47:0] m_data;
    logic [15:0] m_count;

    operand_packetizer #(.GAP_TIMEOUT(16), .CHECK_ORDER(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .dataout(dataout), .word_valid(word_valid), .word_count(word_count),
        .busy(busy), .err_header(err_header), .err_order(err_order),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pos = 0; m_app = 3'd0; m_data = 48'h0; m_count = 16'h0;
        chk("rst_dataout", 64'(dataout), 64'h0);
        chk("rst_count", 64'(word_count), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_pulses", 64'({word_valid, err_header, err_order, err_timeout}), 64'h0);
    endtask

    task automatic send_range(input logic [47:0] w, input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++) begin
            rx_data = w[47 - 8*i -: 8];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (i == 0) begin
                chk("pulse_clear", 64'({word_valid, err_header, err_order, err_timeout}), 64'h0);
                chk("busy_first", 64'(busy), 64'h1);
            end
            if (i < hi && maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        end
    endtask

    // Word-level rules: header first, then A0 resync or in-order match with latched app.
    task automatic check_word(input logic [47:0] w);
        logic [2:0] app;
        logic [2:0] pkt;
        int kind;
        bit acc, eh, eo;
        app = w[47:45];
        pkt = w[42:40];
        acc = 0; eh = 0; eo = 0;
        if (!(app inside {3'd1, 3'd2, 3'd3}) || pkt > 3'd1) begin
            eh = 1;
        end else begin
            kind = (w[44] ? 2 : 0) + int'(pkt);
            if (kind == 0) begin
                acc = 1; m_app = app; m_pos = 1;
            end else if (kind == m_pos && app == m_app) begin
                acc = 1; m_pos = (m_pos + 1) % 4;
            end else begin
                eo = 1;
            end
        end
        if (acc) begin
            m_data = w;
            m_count = m_count + 16'd1;
        end
        $display("word %012h -> accept=%0d hdr=%0d ord=%0d count=%0d", w, acc, eh, eo, m_count);
        chk("word_valid", 64'(word_valid), 64'(acc));
        chk("err_header", 64'(err_header), 64'(eh));
        chk("err_order", 64'(err_order), 64'(eo));
        chk("err_timeout", 64'(err_timeout), 64'h0);
        chk("dataout", 64'(dataout), 64'(m_data));
        chk("word_count", 64'(word_count), 64'(m_count));
        chk("busy_done", 64'(busy), 64'h0);
    endtask

    task automatic send_word(input logic [47:0] w, input int maxgap);
        send_range(w, 0, 5, maxgap);
        check_word(w);
    endtask

    initial begin
        logic [47:0] w;
        logic [2:0] app;
        logic [2:0] pkt;

        do_reset();

        // Single A0 word, then verify the pulse lasts one cycle.
        send_word(48'h200000000005, 0);
        @(negedge clk);
        chk("wv_one_cycle", 64'(word_valid), 64'h0);
        chk("dataout_held", 64'(dataout), 64'h200000000005);

        // Full back-to-back sequence A0,A1,B0,B1.
        do_reset();
        send_word(48'h200000000001, 0);
        send_word(48'h210000000002, 0);
        send_word(48'h300000000003, 0);
        send_word(48'h310000000007, 0);
        chk("seq_final_data", 64'(dataout), 64'h310000000007);
        chk("seq_final_count", 64'(word_count), 64'd4);
        // Back at the start of the sequence: an A1 must now be rejected.
        send_word(48'h210000000008, 0);

        // Header failures.
        send_word(48'h220000000009, 0);
        send_word(48'h000000000001, 0);

        // Order failures and resync.
        do_reset();
        send_word(48'h310000000001, 0);
        send_word(48'h200000000002, 0);
        send_word(48'h410000000003, 0);
        send_word(48'h210000000004, 0);
        send_word(48'h300000000005, 1);

        // Gap timeout after three bytes.
        do_reset();
        w = 48'h2000000000AA;
        send_range(w, 0, 2, 0);
        repeat (15) @(negedge clk);
        chk("gap_15_no_to", 64'(err_timeout), 64'h0);
        chk("gap_15_busy", 64'(busy), 64'h1);
        @(negedge clk);
        chk("gap_16_to", 64'(err_timeout), 64'h1);
        chk("gap_16_idle", 64'(busy), 64'h0);
        @(negedge clk);
        chk("to_one_cycle", 64'(err_timeout), 64'h0);
        send_word(48'h2000000000BB, 0);

        // Byte arriving on the 16th idle cycle rescues the word.
        w = 48'h2100000000CC;
        send_range(w, 0, 2, 0);
        repeat (15) @(negedge clk);
        send_range(w, 3, 3, 0);
        chk("rescue_no_to", 64'(err_timeout), 64'h0);
        chk("rescue_busy", 64'(busy), 64'h1);
        send_range(w, 4, 5, 0);
        check_word(w);

        // Reset in the middle of a word.
        send_range(48'h300000000011, 0, 3, 0);
        do_reset();
        send_word(48'h20000000000A, 0);

        // Randomized words, half of them steered to be the next expected one.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                app = (m_pos == 0) ? 3'($urandom_range(3, 1)) : m_app;
                w = {app, 1'(m_pos / 2), 1'($urandom_range(1, 0)), 3'(m_pos % 2),
                     40'({$urandom, $urandom})};
            end else begin
                app = 3'($urandom_range(3, 0));
                pkt = 3'($urandom_range(2, 0));
                w = {app, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), pkt,
                     40'({$urandom, $urandom})};
            end
            send_word(w, 3);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
